// File: rtl/mio_bus_responder_pkg.sv
// Shared definitions for the MIO bus responder: address map, FSM states and
// the region decode used to steer each access.
package mio_pkg;

  localparam logic [3:0]  RAM_REGION = 4'h0;
  localparam logic [31:0] GPIO_ADDR  = 32'hF000_0000;
  localparam logic [31:0] SW_ADDR    = 32'hE000_0000;
  localparam logic [31:0] CNT_ADDR   = 32'hE000_0004;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_GPIO,
    REG_SW,
    REG_CNT,
    REG_NONE
  } region_t;

  // Byte lane bits are ignored, so only the word address is compared.
  function automatic region_t decode_region(input logic [31:0] a);
    if (a[31:28] == RAM_REGION)          return REG_RAM;
    else if (a[31:2] == GPIO_ADDR[31:2]) return REG_GPIO;
    else if (a[31:2] == SW_ADDR[31:2])   return REG_SW;
    else if (a[31:2] == CNT_ADDR[31:2])  return REG_CNT;
    else                                 return REG_NONE;
  endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// CPU-to-memory/IO bus: level-held request from the CPU, one-cycle ready
// pulse plus registered read data and error flag from the responder.
interface mio_bus_responder_if;
  logic        cpu_mio;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] data_from_cpu;
  logic [31:0] data_to_cpu;
  logic        mio_ready;
  logic        bus_err;

  modport master (
    output cpu_mio, mem_read, mem_write, addr, data_from_cpu,
    input  data_to_cpu, mio_ready, bus_err
  );

  modport slave (
    input  cpu_mio, mem_read, mem_write, addr, data_from_cpu,
    output data_to_cpu, mio_ready, bus_err
  );
endinterface

// File: rtl/mio_bus_responder_ram.sv
// On-chip word RAM: synchronous write, registered (one-cycle) read.
module mio_bus_ram #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: captures a CPU request, inserts wait states, then
// completes the access against RAM, GPIO, switches or the cycle counter.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 1,
  parameter int GPIO_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_responder_if.slave bus,
  input  logic [GPIO_W-1:0] sw_in,
  output logic [GPIO_W-1:0] gpio_out
);

  state_t            state_reg, state_next;
  logic [3:0]        wait_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic              rd_reg, wr_reg;
  logic              err_reg;
  logic [31:0]       data_reg;
  logic [31:0]       cnt_reg;
  logic [GPIO_W-1:0] sw_meta_reg, sw_sync_reg;
  logic [GPIO_W-1:0] gpio_reg;

  logic              req;
  logic              capture, commit;
  region_t           region;
  logic              acc_err;
  logic [31:0]       rd_word;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_rdata;

  assign req    = bus.cpu_mio & (bus.mem_read | bus.mem_write);
  assign region = decode_region(addr_reg);
  assign acc_err = (rd_reg & wr_reg) | (region == REG_NONE) |
                   (wr_reg & ((region == REG_SW) | (region == REG_CNT)));

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          capture    = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!req) begin
          state_next = IDLE;
        end else if (wait_reg == 4'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // The RAM samples the live bus address on the capture edge so read data is
  // already valid in the first ACCESS cycle, which makes zero wait states work.
  assign ram_addr = (state_reg == IDLE) ? bus.addr[RAM_AW+1:2] : addr_reg[RAM_AW+1:2];
  assign ram_we   = commit & wr_reg & ~acc_err & (region == REG_RAM);

  mio_bus_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_word = 32'd0;
    case (region)
      REG_RAM:  rd_word = ram_rdata;
      REG_GPIO: rd_word = 32'(gpio_reg);
      REG_SW:   rd_word = 32'(sw_sync_reg);
      REG_CNT:  rd_word = cnt_reg;
      default:  rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_reg    <= 4'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      rd_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      err_reg     <= 1'b0;
      data_reg    <= 32'd0;
      cnt_reg     <= 32'd0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
      gpio_reg    <= '0;
    end else begin
      cnt_reg     <= cnt_reg + 32'd1;
      sw_meta_reg <= sw_in;
      sw_sync_reg <= sw_meta_reg;
      if (capture) begin
        addr_reg  <= bus.addr;
        wdata_reg <= bus.data_from_cpu;
        rd_reg    <= bus.mem_read;
        wr_reg    <= bus.mem_write;
        wait_reg  <= 4'(WAIT_CYCLES);
      end else if (state_reg == ACCESS && wait_reg != 4'd0) begin
        wait_reg <= wait_reg - 4'd1;
      end
      if (commit) begin
        err_reg <= acc_err;
        if (wr_reg && !acc_err && region == REG_GPIO) begin
          gpio_reg <= wdata_reg[GPIO_W-1:0];
        end
        // Pure reads always load; unmapped reads see zero from rd_word.
        if (rd_reg && !wr_reg) begin
          data_reg <= rd_word;
        end
      end
    end
  end

  assign bus.mio_ready   = (state_reg == RESP);
  assign bus.bus_err     = (state_reg == RESP) & err_reg;
  assign bus.data_to_cpu = data_reg;
  assign gpio_out        = gpio_reg;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: scoreboarded bus transfers over
// RAM, GPIO, switches, counter, error cases, abort and mid-access reset.
module tb_mio_bus_responder;
  localparam int WAIT = 1;
  localparam int LAT  = 2 + WAIT;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] sw_in;
  logic [15:0] gpio_out;
  logic [31:0] tb_cnt;
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  mio_bus_responder_if bus();

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(WAIT), .GPIO_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .sw_in    (sw_in),
    .gpio_out (gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the free-running cycle counter.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 32'd0;
    else       tb_cnt <= tb_cnt + 32'd1;
  end

  // Drives one request at the current negedge and waits (bounded) for ready.
  task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit keep,
                          output logic [31:0] od, output logic oe, output int lat);
    bus.cpu_mio = 1'b1; bus.mem_read = rd; bus.mem_write = wr;
    bus.addr = a; bus.data_from_cpu = d;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (bus.mio_ready === 1'b1) break;
    end
    od = bus.data_to_cpu;
    oe = bus.bus_err;
    if (!keep) begin
      bus.cpu_mio = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cpu_mio = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.addr = 32'd0; bus.data_from_cpu = 32'd0; sw_in = 16'd0;
    repeat (3) @(negedge clk);
    total++; if (bus.mio_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.mio_ready); end
    total++; if (bus.bus_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.bus_err); end
    total++; if (bus.data_to_cpu !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.data_to_cpu); end
    total++; if (gpio_out !== 16'd0) begin bad++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
    reset = 1'b0;
    @(negedge clk);
    $display("reset: ready=%b err=%b data=%h gpio=%h", bus.mio_ready, bus.bus_err, bus.data_to_cpu, gpio_out);
  endtask

  task automatic test_counter();
    logic [31:0] od; logic oe; int lat; exp_t e;
    sb.push_back('{data: tb_cnt + 32'(1 + WAIT), err: 1'b0, lat: LAT});
    bus_xfer(1'b1, 1'b0, 32'hE000_0004, 32'd0, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd cnt: data=%h err=%b lat=%0d", od, oe, lat);
    total++; if (od !== e.data) begin bad++; $display("FAIL cnt_data got=%h exp=%h", od, e.data); end
    total++; if (oe !== e.err) begin bad++; $display("FAIL cnt_err got=%b exp=%b", oe, e.err); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL cnt_lat got=%0d exp=%0d", lat, e.lat); end
    total++; if (bus.mio_ready !== 1'b0) begin bad++; $display("FAIL cnt_single_pulse got=%b exp=0", bus.mio_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] od; logic oe; int lat; exp_t e; logic [31:0] prev;
    prev = bus.data_to_cpu;
    sb.push_back('{data: prev, err: 1'b0, lat: LAT});
    sb.push_back('{data: 32'hDEAD_BEEF, err: 1'b0, lat: LAT + 1});
    sb.push_back('{data: 32'hDEAD_BEEF, err: 1'b0, lat: LAT});
    bus_xfer(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, od, oe, lat);
    e = sb.pop_front();
    $display("wr ram 0x10: data=%h err=%b lat=%0d", od, oe, lat);
    total++; if (od !== e.data) begin bad++; $display("FAIL ram_wr_data got=%h exp=%h", od, e.data); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL ram_wr_lat got=%0d exp=%0d", lat, e.lat); end
    bus_xfer(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd ram 0x10 b2b: data=%h err=%b lat=%0d", od, oe, lat);
    total++; if (od !== e.data) begin bad++; $display("FAIL ram_rd_data got=%h exp=%h", od, e.data); end
    total++; if (oe !== e.err) begin bad++; $display("FAIL ram_rd_err got=%b exp=%b", oe, e.err); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, e.lat); end
    bus_xfer(1'b1, 1'b0, 32'h0000_1010, 32'd0, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd ram alias 0x1010: data=%h err=%b lat=%0d", od, oe, lat);
    total++; if (od !== e.data) begin bad++; $display("FAIL ram_alias got=%h exp=%h", od, e.data); end
  endtask

  task automatic test_gpio();
    logic [31:0] od; logic oe; int lat; exp_t e;
    bus_xfer(1'b0, 1'b1, 32'hF000_0000, 32'h1234_A5A5, 1'b0, od, oe, lat);
    $display("wr gpio: err=%b gpio=%h", oe, gpio_out);
    total++; if (gpio_out !== 16'hA5A5) begin bad++; $display("FAIL gpio_wr got=%h exp=a5a5", gpio_out); end
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL gpio_wr_err got=%b exp=0", oe); end
    sb.push_back('{data: 32'h0000_A5A5, err: 1'b0, lat: LAT});
    bus_xfer(1'b1, 1'b0, 32'hF000_0000, 32'd0, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd gpio: data=%h err=%b", od, oe);
    total++; if (od !== e.data) begin bad++; $display("FAIL gpio_rd got=%h exp=%h", od, e.data); end
    reset = 1'b1;
    @(negedge clk);
    $display("reset: gpio=%h", gpio_out);
    total++; if (gpio_out !== 16'd0) begin bad++; $display("FAIL gpio_reset got=%h exp=0", gpio_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sw();
    logic [31:0] od; logic oe; int lat; exp_t e;
    sw_in = 16'h00FF;
    repeat (3) @(negedge clk);
    sb.push_back('{data: 32'h0000_00FF, err: 1'b0, lat: LAT});
    bus_xfer(1'b1, 1'b0, 32'hE000_0000, 32'd0, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd sw: data=%h err=%b", od, oe);
    total++; if (od !== e.data) begin bad++; $display("FAIL sw_rd got=%h exp=%h", od, e.data); end
    total++; if (oe !== e.err) begin bad++; $display("FAIL sw_rd_err got=%b exp=%b", oe, e.err); end
    sb.push_back('{data: 32'h0000_00FF, err: 1'b1, lat: LAT});
    bus_xfer(1'b0, 1'b1, 32'hE000_0000, 32'h0000_1234, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("wr sw (ro): data=%h err=%b lat=%0d gpio=%h", od, oe, lat, gpio_out);
    total++; if (oe !== e.err) begin bad++; $display("FAIL sw_wr_err got=%b exp=%b", oe, e.err); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL sw_wr_lat got=%0d exp=%0d", lat, e.lat); end
    total++; if (od !== e.data) begin bad++; $display("FAIL sw_wr_data got=%h exp=%h", od, e.data); end
    total++; if (gpio_out !== 16'd0) begin bad++; $display("FAIL sw_wr_gpio got=%h exp=0", gpio_out); end
  endtask

  task automatic test_errors();
    logic [31:0] od; logic oe; int lat; exp_t e;
    bus_xfer(1'b0, 1'b1, 32'h0000_0000, 32'hC0FF_EE00, 1'b0, od, oe, lat);
    sb.push_back('{data: 32'h0000_00FF, err: 1'b1, lat: LAT});
    bus_xfer(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0BAD, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd+wr 0x0: data=%h err=%b", od, oe);
    total++; if (oe !== e.err) begin bad++; $display("FAIL both_err got=%b exp=%b", oe, e.err); end
    total++; if (od !== e.data) begin bad++; $display("FAIL both_data got=%h exp=%h", od, e.data); end
    sb.push_back('{data: 32'd0, err: 1'b1, lat: LAT});
    bus_xfer(1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd unmapped: data=%h err=%b", od, oe);
    total++; if (od !== e.data) begin bad++; $display("FAIL unmap_data got=%h exp=%h", od, e.data); end
    total++; if (oe !== e.err) begin bad++; $display("FAIL unmap_err got=%b exp=%b", oe, e.err); end
    sb.push_back('{data: 32'hC0FF_EE00, err: 1'b0, lat: LAT});
    bus_xfer(1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd ram 0x0: data=%h err=%b", od, oe);
    total++; if (od !== e.data) begin bad++; $display("FAIL both_ram0 got=%h exp=%h", od, e.data); end
    total++; if (oe !== e.err) begin bad++; $display("FAIL ram0_err got=%b exp=%b", oe, e.err); end
  endtask

  task automatic test_abort();
    logic [31:0] od; logic oe; int lat; exp_t e; logic saw;
    bus_xfer(1'b0, 1'b1, 32'h0000_0004, 32'h1111_1111, 1'b0, od, oe, lat);
    bus.cpu_mio = 1'b1; bus.mem_write = 1'b1; bus.addr = 32'h0000_0004; bus.data_from_cpu = 32'h2222_2222;
    @(posedge clk); @(negedge clk);
    bus.cpu_mio = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mio_ready !== 1'b0) saw = 1'b1;
    end
    bus.mem_write = 1'b0;
    $display("abort wr 0x4: ready_seen=%b", saw);
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", saw); end
    sb.push_back('{data: 32'h1111_1111, err: 1'b0, lat: LAT});
    bus_xfer(1'b1, 1'b0, 32'h0000_0004, 32'd0, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd ram 0x4: data=%h", od);
    total++; if (od !== e.data) begin bad++; $display("FAIL abort_ram1 got=%h exp=%h", od, e.data); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] od; logic oe; int lat; exp_t e;
    bus_xfer(1'b0, 1'b1, 32'h0000_0008, 32'hAAAA_5555, 1'b0, od, oe, lat);
    bus.cpu_mio = 1'b1; bus.mem_write = 1'b1; bus.addr = 32'h0000_0008; bus.data_from_cpu = 32'h5555_AAAA;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (bus.mio_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0", bus.mio_ready); end
    @(posedge clk); @(negedge clk);
    total++; if (bus.mio_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready2 got=%b exp=0", bus.mio_ready); end
    reset = 1'b0;
    bus.cpu_mio = 1'b0; bus.mem_write = 1'b0;
    @(negedge clk);
    sb.push_back('{data: 32'hAAAA_5555, err: 1'b0, lat: LAT});
    bus_xfer(1'b1, 1'b0, 32'h0000_0008, 32'd0, 1'b0, od, oe, lat);
    e = sb.pop_front();
    $display("rd ram 0x8 after reset: data=%h lat=%0d", od, lat);
    total++; if (od !== e.data) begin bad++; $display("FAIL rstmid_ram got=%h exp=%h", od, e.data); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL rstmid_lat got=%0d exp=%0d", lat, e.lat); end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_back_to_back();
    test_gpio();
    test_sw();
    test_errors();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
